// File: rtl/data_mem_unit.sv
// Data memory unit for a single-cycle core: byte-addressed RAM with byte/half/word
// access, one memory-mapped output register, a sticky alignment fault and a store counter.
module data_mem_unit #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] IO_ADDR     = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] ALURes,
    input  logic [31:0] WriteData,
    input  logic [1:0]  DataSize,
    input  logic        DataType,
    output logic [31:0] ReadData,
    output logic [31:0] IoOut,
    output logic        MisalignFault,
    output logic [31:0] FaultAddr,
    output logic [15:0] StoreCount
);

    localparam int          IDX_BITS  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]         mem [DEPTH_WORDS];
    logic [IDX_BITS-1:0] wordIdx;
    logic                ramHit;
    logic                ioHit;
    logic                mapped;
    logic                misaligned;
    logic                storeCommit;
    logic [3:0]          byteEn;
    logic [31:0]         laneData;
    logic [31:0]         oldWord;
    logic [31:0]         shifted;

    // RAM takes priority should the IO window ever overlap the RAM range.
    assign wordIdx     = ALURes[IDX_BITS+1:2];
    assign ramHit      = (ALURes < RAM_BYTES);
    assign ioHit       = !ramHit && (ALURes[31:2] == IO_ADDR[31:2]);
    assign mapped      = ramHit || ioHit;
    assign storeCommit = MemWrite && mapped && !misaligned;

    always_comb begin
        misaligned = 1'b0;
        byteEn     = 4'b1111;
        laneData   = WriteData;
        case (DataSize)
            2'b00: begin
                byteEn   = 4'b0001 << ALURes[1:0];
                laneData = {4{WriteData[7:0]}};
            end
            2'b01: begin
                misaligned = ALURes[0];
                byteEn     = ALURes[1] ? 4'b1100 : 4'b0011;
                laneData   = {2{WriteData[15:0]}};
            end
            2'b10: begin
                misaligned = |ALURes[1:0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Loads see pre-edge contents, which gives old-data behaviour on read-during-write.
    always_comb begin
        oldWord  = ramHit ? mem[wordIdx] : IoOut;
        shifted  = oldWord >> {ALURes[1:0], 3'b000};
        ReadData = 32'h0;
        if (MemRead && mapped && !misaligned) begin
            case (DataSize)
                2'b00:   ReadData = DataType ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
                2'b01:   ReadData = DataType ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
                default: ReadData = shifted;
            endcase
        end
    end

    // RAM has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (!reset && storeCommit && ramHit) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[wordIdx][b*8 +: 8] <= laneData[b*8 +: 8];
                end
            end
        end
    end

    // Output register, store counter and first-fault capture share the async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IoOut         <= 32'h0;
            MisalignFault <= 1'b0;
            FaultAddr     <= 32'h0;
            StoreCount    <= 16'h0;
        end else begin
            if (storeCommit && ioHit) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteEn[b]) begin
                        IoOut[b*8 +: 8] <= laneData[b*8 +: 8];
                    end
                end
            end
            if (storeCommit) begin
                StoreCount <= StoreCount + 16'd1;
            end
            if ((MemWrite || MemRead) && misaligned && !MisalignFault) begin
                MisalignFault <= 1'b1;
                FaultAddr     <= ALURes;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit with hand-computed expectations.
module tb_data_mem_unit;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ALURes;
    logic [31:0] WriteData;
    logic [1:0]  DataSize;
    logic        DataType;
    logic [31:0] ReadData;
    logic [31:0] IoOut;
    logic        MisalignFault;
    logic [31:0] FaultAddr;
    logic [15:0] StoreCount;

    int checkCount;
    int passCount;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    data_mem_unit #(.DEPTH_WORDS(256), .IO_ADDR(32'h0000_0400)) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .ALURes(ALURes),
        .WriteData(WriteData),
        .DataSize(DataSize),
        .DataType(DataType),
        .ReadData(ReadData),
        .IoOut(IoOut),
        .MisalignFault(MisalignFault),
        .FaultAddr(FaultAddr),
        .StoreCount(StoreCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one access at the falling edge and lets the combinational read settle.
    task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [1:0] size,
                                 input logic dtype);
        @(negedge clk);
        MemWrite  = we;
        MemRead   = re;
        ALURes    = addr;
        WriteData = data;
        DataSize  = size;
        DataType  = dtype;
        #1;
    endtask

    task automatic clockAndIdle();
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic doStore(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size);
        applyStimulus(1'b1, 1'b0, addr, data, size, 1'b0);
        clockAndIdle();
    endtask

    task automatic doLoad(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic dtype, input logic [31:0] expected);
        applyStimulus(1'b0, 1'b1, addr, 32'h0, size, dtype);
        checkOutput(tag, ReadData, expected);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset      = 1'b1;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        ALURes     = 32'h0;
        WriteData  = 32'h0;
        DataSize   = SZ_W;
        DataType   = 1'b0;

        #3;
        checkOutput("rst_io", IoOut, 32'h0);
        checkOutput("rst_fault", {31'h0, MisalignFault}, 32'h0);
        checkOutput("rst_faddr", FaultAddr, 32'h0);
        checkOutput("rst_count", {16'h0, StoreCount}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Byte store with sign/zero extension on load
        doStore(32'h34, 32'h0000_0080, SZ_B);
        checkOutput("sb_count", {16'h0, StoreCount}, 32'h1);
        doLoad("lbu_34", 32'h34, SZ_B, 1'b1, 32'h0000_0080);
        doLoad("lb_34", 32'h34, SZ_B, 1'b0, 32'hFFFF_FF80);

        // Word then upper half overwrite
        doStore(32'h40, 32'hDEAD_BEEF, SZ_W);
        doStore(32'h42, 32'h0000_1234, SZ_H);
        doLoad("lw_40", 32'h40, SZ_W, 1'b0, 32'h1234_BEEF);
        doLoad("lhu_40", 32'h40, SZ_H, 1'b1, 32'h0000_BEEF);
        doLoad("lh_40", 32'h40, SZ_H, 1'b0, 32'hFFFF_BEEF);
        doLoad("lh_42", 32'h42, SZ_H, 1'b0, 32'h0000_1234);
        doLoad("lbu_43", 32'h43, SZ_B, 1'b1, 32'h0000_0012);
        applyStimulus(1'b0, 1'b0, 32'h40, 32'h0, SZ_W, 1'b0);
        checkOutput("noread_zero", ReadData, 32'h0);
        checkOutput("count_3", {16'h0, StoreCount}, 32'h3);

        // Misaligned store is suppressed and captures the fault address
        doStore(32'h41, 32'h0000_5678, SZ_H);
        checkOutput("mis_fault", {31'h0, MisalignFault}, 32'h1);
        checkOutput("mis_faddr", FaultAddr, 32'h41);
        checkOutput("mis_count", {16'h0, StoreCount}, 32'h3);
        doLoad("mis_ram", 32'h40, SZ_W, 1'b0, 32'h1234_BEEF);
        doLoad("mis_lw_46", 32'h46, SZ_W, 1'b0, 32'h0);
        clockAndIdle();
        checkOutput("mis_faddr_kept", FaultAddr, 32'h41);
        doLoad("reserved_size", 32'h40, 2'b11, 1'b0, 32'h0);

        // IO register and unmapped accesses
        doStore(32'h400, 32'h0000_00A5, SZ_W);
        checkOutput("io_out", IoOut, 32'h0000_00A5);
        doLoad("io_lw", 32'h400, SZ_W, 1'b0, 32'h0000_00A5);
        doLoad("io_lb", 32'h400, SZ_B, 1'b0, 32'hFFFF_FFA5);
        doStore(32'h402, 32'h0000_3C00, SZ_H);
        checkOutput("io_sh_hi", IoOut, 32'h3C00_00A5);
        doStore(32'h8000, 32'h1111_1111, SZ_W);
        checkOutput("unmap_io", IoOut, 32'h3C00_00A5);
        checkOutput("unmap_count", {16'h0, StoreCount}, 32'h5);
        doLoad("unmap_lw", 32'h8000, SZ_W, 1'b0, 32'h0);

        // Simultaneous store and load returns old data
        doStore(32'h44, 32'hCAFE_F00D, SZ_W);
        applyStimulus(1'b1, 1'b1, 32'h44, 32'h0000_0055, SZ_W, 1'b0);
        checkOutput("rdw_old", ReadData, 32'hCAFE_F00D);
        clockAndIdle();
        doLoad("rdw_new", 32'h44, SZ_W, 1'b0, 32'h0000_0055);

        // Reset pulse clears registers but keeps RAM
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("pulse_fault", {31'h0, MisalignFault}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        doLoad("ram_kept", 32'h40, SZ_W, 1'b0, 32'h1234_BEEF);

        // 65535 RAM stores plus one IO store wrap the counter back to zero
        for (int i = 0; i < 65535; i++) begin
            doStore(32'h10, 32'hA000_0000 | 32'(i), SZ_W);
        end
        checkOutput("count_ffff", {16'h0, StoreCount}, 32'h0000_FFFF);
        doStore(32'h400, 32'h0000_0077, SZ_W);
        checkOutput("count_wrap", {16'h0, StoreCount}, 32'h0);
        checkOutput("wrap_io", IoOut, 32'h0000_0077);
        applyStimulus(1'b0, 1'b1, 32'h3, 32'h0, SZ_W, 1'b0);
        clockAndIdle();
        checkOutput("fault2_addr", FaultAddr, 32'h3);

        // Mid-cycle reset clears state before the next edge; store under reset is blocked
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_io", IoOut, 32'h0);
        checkOutput("mid_count", {16'h0, StoreCount}, 32'h0);
        checkOutput("mid_fault", {31'h0, MisalignFault}, 32'h0);
        checkOutput("mid_faddr", FaultAddr, 32'h0);
        doStore(32'h10, 32'h0BAD_0BAD, SZ_W);
        doStore(32'h400, 32'h0000_0099, SZ_W);
        checkOutput("rst_blk_io", IoOut, 32'h0);
        checkOutput("rst_blk_count", {16'h0, StoreCount}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        doLoad("rst_blk_ram", 32'h10, SZ_W, 1'b0, 32'hA000_FFFE);
        doLoad("ram_kept2", 32'h44, SZ_W, 1'b0, 32'h0000_0055);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit RAM words (power of two, 16..1024).
REQ-002 SHALL have parameter IO_ADDR, default 32'h0000_0400, byte address of the memory-mapped output register.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port MemWrite  input  1  store request this cycle (from core).
REQ-006 SHALL have port MemRead  input  1  load request this cycle (from core).
REQ-007 SHALL have port ALURes  input  32  byte address of the access.
REQ-008 SHALL have port WriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port DataSize  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port DataType  input  1  loads: 0 sign-extend, 1 zero-extend.
REQ-011 SHALL have port ReadData  output  32  extended load result to core.
REQ-012 SHALL have port IoOut  output  32  memory-mapped output register.
REQ-013 SHALL have port MisalignFault  output  1  sticky misaligned/reserved-size fault flag.
REQ-014 SHALL have port FaultAddr  output  32  address of first faulting access.
REQ-015 SHALL have port StoreCount  output  16  count of committed stores (RAM and IO).

Function
REQ-016 SHALL decode RAM hit when ALURes < DEPTH_WORDS*4; word index ALURes[log2(DEPTH_WORDS)+1:2], little-endian byte lanes.
REQ-017 SHALL decode IO hit when ALURes[31:2] == IO_ADDR[31:2]; all other addresses unmapped.
REQ-018 SHALL flag an access misaligned when DataSize=01 and ALURes[0]=1, DataSize=10 and ALURes[1:0]!=0, or DataSize=11.
REQ-019 SHALL drive ReadData combinationally in the same cycle (single-cycle core): selected byte/half/word shifted to bit 0, extended per DataType; word ignores DataType.
REQ-020 SHALL drive ReadData = 0 when MemRead=0, access misaligned, or address unmapped.
REQ-021 SHALL return IoOut contents on an aligned IO-hit load, with same lane select/extension as RAM.
REQ-022 SHALL commit a store at rising clk when MemWrite=1, aligned and mapped, updating only enabled byte lanes (byte 1 lane, half 2 lanes, word 4 lanes).
REQ-023 SHALL suppress misaligned or unmapped stores entirely; neither RAM nor IoOut changes.
REQ-024 SHALL give read-during-write old data: ReadData in the store cycle reflects pre-edge contents.
REQ-025 SHALL, when MemWrite and MemRead both 1, perform the store and present old-data ReadData.
REQ-026 SHALL set MisalignFault at rising clk when (MemWrite or MemRead) and misaligned; it stays 1 until reset.
REQ-027 SHALL load FaultAddr with ALURes only on the edge MisalignFault goes 0->1; later faults leave it unchanged.
REQ-028 SHALL increment StoreCount by 1 per committed store, wrapping 16'hFFFF -> 16'h0000; suppressed stores do not count.

Reset
REQ-029 SHALL, on reset assertion, immediately clear IoOut, MisalignFault, FaultAddr, StoreCount to 0, independent of clk.
REQ-030 SHALL not initialise RAM contents on reset; RAM retains data across reset.
REQ-031 SHALL block all stores and fault capture while reset is 1; a store coinciding with reset assertion does not commit.

Verification
REQ-032 SB: ALURes=0x34, WriteData=0x0000_0080, DataSize=00, MemWrite=1 -> LBU (DataType=1) 0x34 reads 0x0000_0080; LB (DataType=0) reads 0xFFFF_FF80; StoreCount=1.
REQ-033 SW 0xDEAD_BEEF to 0x40, then SH 0x1234 to 0x42 -> LW 0x40 reads 0x1234_BEEF; LHU 0x40 reads 0x0000_BEEF; LH 0x42 reads 0x0000_1234.
REQ-034 SH to 0x41 (misaligned) -> RAM unchanged, StoreCount unchanged, MisalignFault=1, FaultAddr=0x41; later LW at 0x46 keeps FaultAddr=0x41.
REQ-035 SW 0x0000_00A5 to IO_ADDR -> IoOut=0x0000_00A5 next edge; LW IO_ADDR reads 0x0000_00A5; SW to 0x8000 -> no change, LW 0x8000 reads 0.
REQ-036 Store 65536 aligned words -> StoreCount wraps to 0x0000; assert reset mid-cycle -> IoOut/StoreCount/MisalignFault cleared before next edge, prior RAM word still readable.
